// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock.
// Ports: clk, rst (sync, active-high); start, a, b, cin request an add;
//        busy is high while bits are processed; done pulses for one
//        cycle when sum/cout have just been updated. sum/cout are held
//        until the next completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [1:0]       w_add;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;

    // Full-adder cell on the current LSBs.
    assign w_add = {1'b0, a_sh_q[0]}
                 + {1'b0, b_sh_q[0]}
                 + {1'b0, carry_q};

    // New sum bit enters at the MSB; shift form stays legal for WIDTH=1.
    assign res_shift = (res_q >> 1)
                     | (WIDTH'(w_add[0]) << (WIDTH - 1));

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_shift;
                carry_d = w_add[1];
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d   = res_shift;
                    cout_d  = w_add[1];
                    state_d = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder at WIDTH=8
// and WIDTH=1, sampled on the falling edge.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done),
        .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t tbl[5];
    logic [1:0] exp1[8];

    task automatic chk(input string nm,
                       input logic [8:0] act,
                       input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Start at edge k, expect 8 busy cycles, one done cycle,
    // then quiet with the result held.
    task automatic run_op(input logic [7:0] va,
                          input logic [7:0] vb,
                          input logic       vc,
                          input logic [7:0] es,
                          input logic       ec);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; cin = vc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("run_busy", {8'h0, busy}, 9'h1);
            chk("run_done_lo", {8'h0, done}, 9'h0);
            a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
        end
        chk("end_done", {8'h0, done}, 9'h1);
        chk("end_busy", {8'h0, busy}, 9'h0);
        chk("end_res", {cout, sum}, {ec, es});
        @(negedge clk);
        chk("after_done", {8'h0, done}, 9'h0);
        chk("held_res", {cout, sum}, {ec, es});
    endtask

    initial begin
        tbl[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0};
        exp1 = '{2'b00, 2'b01, 2'b01, 2'b10,
                 2'b01, 2'b10, 2'b10, 2'b11};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        // Reset then idle.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            chk("idle", {busy, done, cout, sum[5:0]}, 9'h0);
            chk("idle_sum", {1'b0, sum}, 9'h0);
        end

        // Table-driven adds.
        for (int i = 0; i < 5; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin,
                   tbl[i].s, tbl[i].co);

        // start held high: in-flight op ignores it, and the
        // next op launches from DONE with no bubble.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk("b2b_busy", {8'h0, busy}, 9'h1);
                chk("b2b_done_lo", {8'h0, done}, 9'h0);
                a = 8'($urandom); b = 8'($urandom);
                cin = 1'($urandom);
            end
            @(negedge clk);
            chk("b2b_done", {8'h0, done}, 9'h1);
            chk("b2b_res", {cout, sum},
                (op == 0) ? 9'h030 : 9'h033);
            if (op == 0) begin
                a = 8'h11; b = 8'h22; cin = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_quiet", {7'h0, busy, done}, 9'h0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mid_busy", {8'h0, busy}, 9'h1);
            if (i < 3) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ctl", {7'h0, busy, done}, 9'h0);
        chk("rst_res", {cout, sum}, 9'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_no_done", {7'h0, busy, done}, 9'h0);
        end
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start1 = 1'b1;
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
            @(negedge clk);
            start1 = 1'b0;
            chk("w1_busy", {7'h0, busy1, done1}, 9'h2);
            @(negedge clk);
            chk("w1_done", {7'h0, busy1, done1}, 9'h1);
            chk("w1_res", {7'h0, cout1, sum1},
                {7'h0, exp1[i]});
            @(negedge clk);
            chk("w1_quiet", {7'h0, busy1, done1}, 9'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
